// File: rtl/multiplier_pkg.sv
// Shared types for the shift-add multiplier: sequencer states, default width
// and the per-cycle datapath command encoding.
package multiplier_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} mult_state_t;

    localparam int MULT_WIDTH_DEFAULT = 4;

    // One command per cycle reaches the C/A/Q register; NONE means hold.
    typedef enum logic [1:0] {
        CMD_NONE      = 2'd0,
        CMD_LOAD      = 2'd1,
        CMD_ADD_SHIFT = 2'd2,
        CMD_SHIFT     = 2'd3
    } step_cmd_t;

    // Encode the three one-hot strobes. Overlapping strobes are not legal,
    // so priority here is arbitrary.
    function automatic step_cmd_t step_cmd(input logic load, input logic add_shift,
                                           input logic shift);
        step_cmd_t c;
        c = CMD_NONE;
        if (load)           c = CMD_LOAD;
        else if (add_shift) c = CMD_ADD_SHIFT;
        else if (shift)     c = CMD_SHIFT;
        return c;
    endfunction

endpackage

// File: rtl/multiplier_control_step_counter.sv
// Counts CALC steps; flags the final step and wraps to zero after it.
module step_counter #(
    parameter int WIDTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count;

    assign last = (count == CW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (enable)
            count <= last ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/multiplier_control.sv
// Sequencer for the shift-add multiplier: LOAD once, WIDTH add/shift steps
// chosen by the AQ LSB, then hold DONE until acknowledged.
module multiplier_control
    import multiplier_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic ack,
    input  logic q0,
    output logic load,
    output logic add_shift,
    output logic shift,
    output logic busy,
    output logic done
);

    mult_state_t state, state_next;
    step_cmd_t   cmd;
    logic        last;

    // Counter is held at zero outside CALC, so every operation starts from step 0.
    step_counter #(.WIDTH(WIDTH)) u_step_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (state != CALC),
        .enable (state == CALC),
        .last   (last)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = CALC;
            CALC: if (last)  state_next = DONE;
            DONE: if (ack)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd = CMD_NONE;
        case (state)
            LOAD:    cmd = CMD_LOAD;
            CALC:    cmd = q0 ? CMD_ADD_SHIFT : CMD_SHIFT;
            default: cmd = CMD_NONE;
        endcase
        load      = (cmd == CMD_LOAD);
        add_shift = (cmd == CMD_ADD_SHIFT);
        shift     = (cmd == CMD_SHIFT);
        busy      = (state == LOAD) || (state == CALC);
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench: sequencer driving a behavioural C/A/Q register and adder.
module tb_multiplier_control;
    import multiplier_pkg::*;

    localparam int W = MULT_WIDTH_DEFAULT;

    logic clock = 0;
    logic reset, start, ack;
    logic load, add_shift, shift, busy, done;
    logic [W-1:0] mcand, qin;
    logic         creg;
    logic [W-1:0] areg, qreg;
    logic [W:0]   sum;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    multiplier_control #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .ack       (ack),
        .q0        (qreg[0]),
        .load      (load),
        .add_shift (add_shift),
        .shift     (shift),
        .busy      (busy),
        .done      (done)
    );

    // Datapath register and adder
    assign sum = {1'b0, areg} + {1'b0, mcand};
    always @(posedge clock) begin
        if (load) begin
            creg <= 1'b0; areg <= '0; qreg <= qin;
        end else if (add_shift) begin
            {creg, areg, qreg} <= {1'b0, sum, qreg[W-1:1]};
        end else if (shift) begin
            {creg, areg, qreg} <= {1'b0, creg, areg, qreg[W-1:1]};
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes must never overlap outside reset
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            checks++;
            assert ($onehot0({load, add_shift, shift})) else begin
                errors++;
                $error("FAIL onehot: observed=%b expected at most one", {load, add_shift, shift});
            end
        end
    end

    task automatic idle_outputs(input string tag);
        chk(tag, {11'd0, load, add_shift, shift, busy, done}, 16'd0);
    endtask

    // Full operation; pat[i] is the hand-computed step i (1=add_shift, 0=shift).
    task automatic do_mult(input logic [W-1:0] m, input logic [W-1:0] q,
                           input logic [W-1:0] pat, input logic [2*W-1:0] prod,
                           input bit give_ack);
        mcand = m; qin = q;
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
        chk("load_cycle", {13'd0, load, busy, done}, 16'b110);
        for (int i = 0; i < W; i++) begin
            @(negedge clock);
            chk("calc_step", {12'd0, step_cmd(load, add_shift, shift), busy, done},
                {12'd0, pat[i] ? CMD_ADD_SHIFT : CMD_SHIFT, 1'b1, 1'b0});
        end
        @(negedge clock);
        chk("done_cycle", {14'd0, busy, done}, 16'b01);
        chk("product", {8'd0, areg, qreg}, {8'd0, prod});
        if (give_ack) begin
            ack = 1;
            @(negedge clock); ack = 0;
            idle_outputs("after_ack");
        end
    endtask

    initial begin
        reset = 1; start = 0; ack = 0; mcand = 0; qin = 0;
        repeat (3) @(negedge clock);
        idle_outputs("in_reset");
        reset = 0;
        repeat (5) begin
            @(negedge clock);
            idle_outputs("idle");
        end

        do_mult(4'd13, 4'b1011, 4'b1011, 8'd143, 1);
        do_mult(4'd13, 4'b0000, 4'b0000, 8'd0,   1);
        do_mult(4'd15, 4'b1111, 4'b1111, 8'd225, 1);

        // Reset during second CALC cycle
        mcand = 4'd9; qin = 4'b0110;
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;   // LOAD
        @(negedge clock);              // CALC 1
        @(negedge clock); reset = 1;   // CALC 2
        chk("calc2_busy", {15'd0, busy}, 16'd1);
        @(negedge clock); reset = 0;
        idle_outputs("mid_reset");
        @(negedge clock);
        idle_outputs("post_reset_idle");
        do_mult(4'd13, 4'b1011, 4'b1011, 8'd143, 1);

        // start held through DONE; ack wins, then restart after one IDLE cycle
        do_mult(4'd5, 4'b0011, 4'b0011, 8'd15, 0);
        start = 1;
        repeat (10) begin
            @(negedge clock);
            chk("hold_done", {12'd0, load, add_shift, shift, done}, 16'b0001);
            chk("hold_aq", {8'd0, areg, qreg}, 16'd15);
        end
        ack = 1;
        @(negedge clock); ack = 0;
        idle_outputs("ack_idle");
        @(negedge clock); start = 0;
        chk("restart_load", {14'd0, load, busy}, 16'b11);
        repeat (W + 1) @(negedge clock);
        chk("restart_done", {15'd0, done}, 16'd1);
        chk("restart_prod", {8'd0, areg, qreg}, 16'd15);
        ack = 1;
        @(negedge clock); ack = 0;
        idle_outputs("restart_ack");

        // ack outside DONE is ignored
        ack = 1;
        @(negedge clock);
        idle_outputs("stray_ack");
        ack = 0;

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                do_mult(W'(a), W'(b), W'(b), 8'(a * b), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
